// File: rtl/csr_file.sv
// csr_file: machine-mode CSR storage with atomic read-modify-write, 64-bit cycle/instret counters
// Ports: clk/reset (async, active-high); req_valid/req_ready handshake carrying read_enable,
// write_enable, write_func (01 RW, 10 RS, 11 RC), input_select (0 rs1_value, 1 uimm), csr_addr;
// resp_valid/resp_ready handshake returning resp_rdata (old value) and resp_illegal;
// instr_retire bumps minstret.
module csr_file #(
  parameter logic [31:0] HART_ID    = 32'd0,
  parameter logic [31:0] MISA_VALUE = 32'h4000_0100
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        read_enable,
  input  logic        write_enable,
  input  logic [1:0]  write_func,
  input  logic        input_select,
  input  logic [11:0] csr_addr,
  input  logic [31:0] rs1_value,
  input  logic [4:0]  uimm,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_illegal,
  input  logic        instr_retire
);
  logic [31:0] r_mstatus, r_mtvec, r_mscratch, r_mepc, r_mcause;
  logic [63:0] r_mcycle, r_minstret;
  logic        r_resp_valid, r_resp_illegal;
  logic [31:0] r_resp_rdata;
  logic        w_sup, w_accept, w_illegal, w_wr;
  logic [31:0] w_old, w_op, w_new;
  logic        w_wr_cl, w_wr_ch, w_wr_il, w_wr_ih;
  logic [63:0] w_cyc_inc, w_ins_inc, w_mcycle_n, w_minstret_n;
  assign req_ready    = !r_resp_valid | resp_ready;
  assign resp_valid   = r_resp_valid;
  assign resp_rdata   = r_resp_rdata;
  assign resp_illegal = r_resp_illegal;
  assign w_accept     = req_valid & req_ready;
  always_comb begin
    w_sup = 1'b1;
    w_old = 32'd0;
    case (csr_addr)
      12'h300: w_old = r_mstatus;
      12'h301: w_old = MISA_VALUE;
      12'h305: w_old = r_mtvec;
      12'h340: w_old = r_mscratch;
      12'h341: w_old = r_mepc;
      12'h342: w_old = r_mcause;
      12'hB00: w_old = r_mcycle[31:0];
      12'hB02: w_old = r_minstret[31:0];
      12'hB80: w_old = r_mcycle[63:32];
      12'hB82: w_old = r_minstret[63:32];
      12'hF14: w_old = HART_ID;
      default: w_sup = 1'b0;
    endcase
  end
  assign w_illegal = ((read_enable | write_enable) & !w_sup) | (write_enable & (csr_addr[11:10] == 2'b11));
  assign w_wr      = w_accept & write_enable & (write_func != 2'b00) & !w_illegal;
  assign w_op      = input_select ? {27'd0, uimm} : rs1_value;
  assign w_new     = write_func == 2'b01 ? w_op : write_func == 2'b10 ? (w_old | w_op) : (w_old & ~w_op);
  assign w_wr_cl   = w_wr & (csr_addr == 12'hB00);
  assign w_wr_ch   = w_wr & (csr_addr == 12'hB80);
  assign w_wr_il   = w_wr & (csr_addr == 12'hB02);
  assign w_wr_ih   = w_wr & (csr_addr == 12'hB82);
  assign w_cyc_inc = r_mcycle + 64'd1;
  assign w_ins_inc = r_minstret + {63'd0, instr_retire};
  // A written half replaces the increment and freezes the other half, which also kills the low->high carry
  assign w_mcycle_n = {w_wr_ch ? w_new : w_wr_cl ? r_mcycle[63:32] : w_cyc_inc[63:32],
                       w_wr_cl ? w_new : w_wr_ch ? r_mcycle[31:0]  : w_cyc_inc[31:0]};
  assign w_minstret_n = {w_wr_ih ? w_new : w_wr_il ? r_minstret[63:32] : w_ins_inc[63:32],
                         w_wr_il ? w_new : w_wr_ih ? r_minstret[31:0]  : w_ins_inc[31:0]};
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mstatus      <= 32'd0;
      r_mtvec        <= 32'd0;
      r_mscratch     <= 32'd0;
      r_mepc         <= 32'd0;
      r_mcause       <= 32'd0;
      r_mcycle       <= 64'd0;
      r_minstret     <= 64'd0;
      r_resp_valid   <= 1'b0;
      r_resp_rdata   <= 32'd0;
      r_resp_illegal <= 1'b0;
    end else begin
      r_mcycle   <= w_mcycle_n;
      r_minstret <= w_minstret_n;
      if (w_wr && csr_addr == 12'h300) r_mstatus  <= w_new & 32'h0000_0088;
      if (w_wr && csr_addr == 12'h305) r_mtvec    <= w_new & ~32'd3;
      if (w_wr && csr_addr == 12'h340) r_mscratch <= w_new;
      if (w_wr && csr_addr == 12'h341) r_mepc     <= w_new & ~32'd3;
      if (w_wr && csr_addr == 12'h342) r_mcause   <= w_new;
      if (w_accept) begin
        r_resp_valid   <= 1'b1;
        r_resp_rdata   <= (read_enable & !w_illegal) ? w_old : 32'd0;
        r_resp_illegal <= w_illegal;
      end else if (resp_ready) begin
        r_resp_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_csr_file.sv
// tb_csr_file: directed and randomized checks of csr_file against a behavioural CSR model
module tb_csr_file;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0, read_enable = 1'b0, write_enable = 1'b0, input_select = 1'b0;
  logic [1:0]  write_func = 2'd0;
  logic [11:0] csr_addr = 12'd0;
  logic [31:0] rs1_value = 32'd0;
  logic [4:0]  uimm = 5'd0;
  logic        resp_ready = 1'b1, instr_retire = 1'b0;
  logic        req_ready, resp_valid, resp_illegal;
  logic [31:0] resp_rdata;
  int n_chk = 0, n_pass = 0;
  logic [31:0] m_mstatus, m_mtvec, m_mscratch, m_mepc, m_mcause;
  logic [63:0] m_cycle, m_instret;
  logic        m_rv, m_il;
  logic [31:0] m_rd;
  logic [11:0] addrs [14] = '{12'h300, 12'h301, 12'h305, 12'h340, 12'h341, 12'h342, 12'hB00,
                              12'hB02, 12'hB80, 12'hB82, 12'hF14, 12'h7C0, 12'h123, 12'hB01};
  csr_file dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .read_enable(read_enable), .write_enable(write_enable), .write_func(write_func),
    .input_select(input_select), .csr_addr(csr_addr), .rs1_value(rs1_value), .uimm(uimm),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_illegal(resp_illegal), .instr_retire(instr_retire)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask
  task automatic mzero();
    {m_mstatus, m_mtvec, m_mscratch, m_mepc, m_mcause} = '0;
    m_cycle = 64'd0;
    m_instret = 64'd0;
    m_rv = 1'b0;
    m_il = 1'b0;
    m_rd = 32'd0;
  endtask
  function automatic logic [32:0] mread(input logic [11:0] a);
    case (a)
      12'h300: return {1'b1, m_mstatus};
      12'h301: return {1'b1, 32'h4000_0100};
      12'h305: return {1'b1, m_mtvec};
      12'h340: return {1'b1, m_mscratch};
      12'h341: return {1'b1, m_mepc};
      12'h342: return {1'b1, m_mcause};
      12'hB00: return {1'b1, m_cycle[31:0]};
      12'hB02: return {1'b1, m_instret[31:0]};
      12'hB80: return {1'b1, m_cycle[63:32]};
      12'hB82: return {1'b1, m_instret[63:32]};
      12'hF14: return {1'b1, 32'd0};
      default: return 33'd0;
    endcase
  endfunction
  task automatic cyc(input logic v, re, we, input logic [1:0] wf, input logic sel,
                     input logic [11:0] a, input logic [31:0] rs, input logic [4:0] u,
                     input logic rr, ret);
    logic sup, ill, acc, wr;
    logic [31:0] old, op, nv;
    logic [63:0] cn, in_n;
    req_valid = v; read_enable = re; write_enable = we; write_func = wf; input_select = sel;
    csr_addr = a; rs1_value = rs; uimm = u; resp_ready = rr; instr_retire = ret;
    #1;
    check("req_ready", req_ready, !m_rv | rr);
    {sup, old} = mread(a);
    op = sel ? {27'd0, u} : rs;
    ill = ((re | we) & !sup) | (we & a[11:10] == 2'b11);
    acc = v & (!m_rv | rr);
    wr = acc & we & wf != 2'd0 & !ill;
    nv = wf == 2'd1 ? op : wf == 2'd2 ? (old | op) : (old & ~op);
    cn = m_cycle + 64'd1;
    in_n = m_instret + 64'(ret);
    if (wr)
      case (a)
        12'h300: m_mstatus = nv & 32'h88;
        12'h305: m_mtvec = nv & ~32'd3;
        12'h340: m_mscratch = nv;
        12'h341: m_mepc = nv & ~32'd3;
        12'h342: m_mcause = nv;
        12'hB00: cn = {m_cycle[63:32], nv};
        12'hB80: cn = {nv, m_cycle[31:0]};
        12'hB02: in_n = {m_instret[63:32], nv};
        12'hB82: in_n = {nv, m_instret[31:0]};
        default: ;
      endcase
    @(posedge clk);
    #1;
    m_cycle = cn;
    m_instret = in_n;
    if (acc) begin
      m_rv = 1'b1;
      m_rd = (re & !ill) ? old : 32'd0;
      m_il = ill;
    end else if (rr) m_rv = 1'b0;
    check("resp_valid", resp_valid, m_rv);
    if (m_rv) begin
      check("resp_rdata", resp_rdata, m_rd);
      check("resp_illegal", resp_illegal, m_il);
    end
  endtask
  task automatic req(input logic re, we, input logic [1:0] wf, input logic sel,
                     input logic [11:0] a, input logic [31:0] rs, input logic [4:0] u);
    cyc(1'b1, re, we, wf, sel, a, rs, u, 1'b1, 1'b0);
  endtask
  task automatic idle(input logic ret);
    cyc(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 12'd0, 32'd0, 5'd0, 1'b1, ret);
  endtask
  initial begin
    logic hold, v, re, we, sel, rr;
    logic [1:0] wf;
    logic [11:0] a;
    logic [31:0] rs;
    logic [4:0] u;
    mzero();
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("rst_valid", resp_valid, 1'b0);
    check("rst_rdata", resp_rdata, 32'd0);
    check("rst_illegal", resp_illegal, 1'b0);
    req(1, 1, 2'd1, 0, 12'h340, 32'hDEADBEEF, 5'd0);
    req(1, 1, 2'd2, 1, 12'h340, 32'd0, 5'd5);
    check("ms_rs_old", resp_rdata, 32'hDEADBEEF);
    req(1, 0, 2'd0, 0, 12'h340, 32'd0, 5'd0);
    check("ms_after_rs", resp_rdata, 32'hDEADBEEF);
    req(1, 1, 2'd1, 0, 12'h340, 32'h12345678, 5'd0);
    req(1, 1, 2'd3, 0, 12'h340, 32'h0000FFFF, 5'd0);
    check("ms_rc_old", resp_rdata, 32'h12345678);
    req(1, 0, 2'd0, 0, 12'h340, 32'd0, 5'd0);
    check("ms_after_rc", resp_rdata, 32'h12340000);
    req(0, 1, 2'd1, 0, 12'hB80, 32'd0, 5'd0);
    req(0, 1, 2'd1, 0, 12'hB00, 32'hFFFFFFFF, 5'd0);
    idle(0);
    idle(0);
    req(1, 0, 2'd0, 0, 12'hB80, 32'd0, 5'd0);
    check("mcycleh_carry", resp_rdata, 32'd1);
    req(1, 1, 2'd1, 0, 12'hF14, 32'h55, 5'd0);
    check("hartid_wr_ill", resp_illegal, 1'b1);
    req(1, 1, 2'd1, 0, 12'h7C0, 32'h55, 5'd0);
    check("unsup_ill", resp_illegal, 1'b1);
    check("unsup_rdata", resp_rdata, 32'd0);
    req(1, 1, 2'd1, 0, 12'h300, 32'hFFFFFFFF, 5'd0);
    req(1, 0, 2'd0, 0, 12'h300, 32'd0, 5'd0);
    check("mstatus_mask", resp_rdata, 32'h88);
    req(1, 1, 2'd1, 0, 12'h305, 32'h1003, 5'd0);
    req(1, 0, 2'd0, 0, 12'h305, 32'd0, 5'd0);
    check("mtvec_mask", resp_rdata, 32'h1000);
    req(1, 0, 2'd0, 0, 12'h340, 32'd0, 5'd0);
    for (int i = 0; i < 3; i++) begin
      cyc(1, 1, 1, 2'd2, 0, 12'h340, 32'h0000_0F00, 5'd0, 1'b0, 1'b0);
      check("stall_ready", req_ready, 1'b0);
    end
    cyc(1, 1, 1, 2'd2, 0, 12'h340, 32'h0000_0F00, 5'd0, 1'b1, 1'b0);
    req(1, 0, 2'd0, 0, 12'h340, 32'd0, 5'd0);
    check("stall_once", resp_rdata, 32'h12340F00);
    req(1, 1, 2'd1, 0, 12'h340, 32'hA5, 5'd0);
    cyc(0, 0, 0, 2'd0, 0, 12'd0, 32'd0, 5'd0, 1'b0, 1'b0);
    reset = 1'b1;
    #1;
    check("async_rst_valid", resp_valid, 1'b0);
    check("async_rst_rdata", resp_rdata, 32'd0);
    mzero();
    @(posedge clk);
    #1;
    reset = 1'b0;
    req(1, 0, 2'd0, 0, 12'h340, 32'd0, 5'd0);
    check("ms_after_rst", resp_rdata, 32'd0);
    for (int i = 0; i < 10; i++) idle(1);
    req(1, 0, 2'd0, 0, 12'hB02, 32'd0, 5'd0);
    check("minstret_10", resp_rdata, 32'd10);
    hold = 1'b0;
    {v, re, we, sel, wf, a, rs, u} = '0;
    for (int i = 0; i < 4000; i++) begin
      if (!hold) begin
        v = $urandom_range(0, 3) != 0;
        re = 1'($urandom);
        we = 1'($urandom);
        wf = 2'($urandom);
        sel = 1'($urandom);
        a = addrs[$urandom_range(0, 13)];
        rs = $urandom;
        u = 5'($urandom);
      end
      rr = $urandom_range(0, 3) != 0;
      hold = v & m_rv & !rr;
      cyc(v, re, we, wf, sel, a, rs, u, rr, 1'($urandom));
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
